// File: rtl/xbar_rr_switch_pkg.sv
// rtl/xbar_rr_switch_pkg.sv - shared NoC constants and per-port layout helpers
//
// Purpose: default flit width, port counts, index-width helper and the
// packed-slice offset helper used for every per-port bus of the crossbar.
// Ports: none (package).

package xbar_rr_switch_pkg;

    localparam int FLIT_WIDTH_DEF    = 32;
    localparam int IN_PORTS_DEF      = 5;
    localparam int OUT_PORTS_DEF     = 5;
    localparam int OUT_PORT_BITS_DEF = 3;

    // Bits needed to index n ports; never returns 0 so a 1-port build still works.
    function automatic int port_idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Low bit of port idx's field in a bus packed as port 0 at the LSBs.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/xbar_rr_switch_arbiter.sv
// rtl/xbar_rr_switch_arbiter.sv - round-robin arbiter with registered priority pointer
//
// Purpose: grants one requester per cycle, searching from ptr+1 upward with
// wrap-around; the pointer moves to the winner only when a grant is issued.
// Ports:
//   clk, reset : clock, synchronous active-high reset (ptr <= N-1)
//   req[N]     : request vector
//   en         : grant permission for this cycle
//   gnt[N]     : one-hot grant, combinational
//   ptr        : last winner (priority starts after it)

module rr_arbiter
    import xbar_rr_switch_pkg::*;
#(
    parameter  int N     = 5,
    localparam int PTR_W = port_idx_bits(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] ptr
);

    logic             found;
    logic [PTR_W-1:0] winner;

    always_comb begin
        gnt    = '0;
        found  = 1'b0;
        winner = ptr;
        for (int k = 1; k <= N; k++) begin
            logic [PTR_W-1:0] cand;
            cand = PTR_W'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        if (found && en) begin
            gnt[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= PTR_W'(N - 1);
        end else if (found && en) begin
            ptr <= winner;
        end
    end

endmodule

// File: rtl/xbar_rr_switch.sv
// rtl/xbar_rr_switch.sv - registered NoC crossbar with per-output round-robin arbitration
//
// Purpose: routes flits from IN_PORTS inputs to OUT_PORTS one-entry output
// registers, arbitrating each output independently; flits with an illegal
// destination are consumed and reported on bad_dest.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   ON                    : switch enable; 0 blocks new grants and drops
//   in_valid/in_data      : input flits (port i at slice i)
//   req_ports             : destination per input (OUT_PORT_BITS each)
//   in_ready              : combinational consume strobe per input
//   out_data/out_valid    : registered output flits
//   out_ready             : downstream accept per output
//   bad_dest              : registered 1-cycle illegal-destination pulse

module xbar_rr_switch
    import xbar_rr_switch_pkg::*;
#(
    parameter int DATA_WIDTH    = FLIT_WIDTH_DEF,
    parameter int IN_PORTS      = IN_PORTS_DEF,
    parameter int OUT_PORTS     = OUT_PORTS_DEF,
    parameter int OUT_PORT_BITS = OUT_PORT_BITS_DEF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            ON,
    input  logic [IN_PORTS-1:0]             in_valid,
    input  logic [IN_PORTS*DATA_WIDTH-1:0]  in_data,
    input  logic [IN_PORTS*OUT_PORT_BITS-1:0] req_ports,
    output logic [IN_PORTS-1:0]             in_ready,
    output logic [OUT_PORTS*DATA_WIDTH-1:0] out_data,
    output logic [OUT_PORTS-1:0]            out_valid,
    input  logic [OUT_PORTS-1:0]            out_ready,
    output logic [IN_PORTS-1:0]             bad_dest
);

    localparam int PTR_W = port_idx_bits(IN_PORTS);

    logic [OUT_PORT_BITS-1:0] dest       [IN_PORTS];
    logic [IN_PORTS-1:0]      req_mat    [OUT_PORTS];
    logic [IN_PORTS-1:0]      gnt_mat    [OUT_PORTS];
    logic [PTR_W-1:0]         rr_ptr     [OUT_PORTS];
    logic [DATA_WIDTH-1:0]    mux_data   [OUT_PORTS];
    logic [OUT_PORTS-1:0]     can_accept;
    logic [OUT_PORTS-1:0]     arb_en;
    logic [IN_PORTS-1:0]      illegal;
    logic [IN_PORTS-1:0]      granted_any;

    // Request decode: each input requests exactly the output it names, so an
    // input can appear in at most one column of req_mat.
    always_comb begin
        illegal = '0;
        for (int i = 0; i < IN_PORTS; i++) begin
            dest[i]    = req_ports[slice_lo(i, OUT_PORT_BITS) +: OUT_PORT_BITS];
            illegal[i] = in_valid[i] & (int'(dest[i]) >= OUT_PORTS);
        end
        for (int j = 0; j < OUT_PORTS; j++) begin
            for (int i = 0; i < IN_PORTS; i++) begin
                req_mat[j][i] = in_valid[i] & (int'(dest[i]) == j);
            end
        end
    end

    // A full register may be refilled in the same cycle it drains.
    assign can_accept = ~out_valid | out_ready;
    assign arb_en     = can_accept & {OUT_PORTS{ON & ~reset}};

    for (genvar j = 0; j < OUT_PORTS; j++) begin : g_arb
        rr_arbiter #(
            .N (IN_PORTS)
        ) u_arb (
            .clk   (clk),
            .reset (reset),
            .req   (req_mat[j]),
            .en    (arb_en[j]),
            .gnt   (gnt_mat[j]),
            .ptr   (rr_ptr[j])
        );

        always @(posedge clk) begin
            if (!reset) begin
                assert (int'(rr_ptr[j]) < IN_PORTS);
            end
        end
    end

    // One-hot grant makes an AND-OR mux sufficient.
    always_comb begin
        granted_any = '0;
        for (int j = 0; j < OUT_PORTS; j++) begin
            mux_data[j] = '0;
            for (int i = 0; i < IN_PORTS; i++) begin
                mux_data[j] = mux_data[j]
                            | ({DATA_WIDTH{gnt_mat[j][i]}}
                               & in_data[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH]);
            end
            granted_any = granted_any | gnt_mat[j];
        end
    end

    assign in_ready = granted_any | (illegal & {IN_PORTS{ON & ~reset}});

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= '0;
            out_data  <= '0;
            bad_dest  <= '0;
        end else begin
            bad_dest <= illegal & {IN_PORTS{ON}};
            for (int j = 0; j < OUT_PORTS; j++) begin
                if (|gnt_mat[j]) begin
                    out_valid[j]                                      <= 1'b1;
                    out_data[slice_lo(j, DATA_WIDTH) +: DATA_WIDTH] <= mux_data[j];
                end else if (out_ready[j]) begin
                    out_valid[j] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_xbar_rr_switch.sv
// tb/tb_xbar_rr_switch.sv - scoreboard testbench for xbar_rr_switch

module tb_xbar_rr_switch;

    localparam int DW = 32;
    localparam int NI = 5;
    localparam int NO = 5;
    localparam int PB = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              ON;
    logic [NI-1:0]     in_valid;
    logic [NI*DW-1:0]  in_data;
    logic [NI*PB-1:0]  req_ports;
    logic [NI-1:0]     in_ready;
    logic [NO*DW-1:0]  out_data;
    logic [NO-1:0]     out_valid;
    logic [NO-1:0]     out_ready;
    logic [NI-1:0]     bad_dest;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] exp_q [NO][$];

    xbar_rr_switch #(
        .DATA_WIDTH    (DW),
        .IN_PORTS      (NI),
        .OUT_PORTS     (NO),
        .OUT_PORT_BITS (PB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ON        (ON),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .req_ports (req_ports),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bad_dest  (bad_dest)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [NO*DW-1:0] act, input logic [NO*DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_flit(input int i, input int d, input logic [DW-1:0] data);
        in_valid[i]          = 1'b1;
        req_ports[i*PB +: PB] = PB'(d);
        in_data[i*DW +: DW]   = data;
    endtask

    task automatic clear_in();
        in_valid  = '0;
        in_data   = '0;
        req_ports = '0;
    endtask

    // Checks in_ready mid-cycle, records the flits the bench expects to be
    // granted, then returns 1 time unit after the next rising edge.
    task automatic tick(input string name, input logic [NI-1:0] exp_ready);
        int d;
        @(negedge clk);
        check(name, NO*DW'(in_ready), NO*DW'(exp_ready));
        for (int i = 0; i < NI; i++) begin
            d = int'(req_ports[i*PB +: PB]);
            if (exp_ready[i] && in_valid[i] && d < NO) begin
                exp_q[d].push_back(in_data[i*DW +: DW]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output handshake must deliver the next expected flit.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                for (int j = 0; j < NO; j++) begin
                    if (out_valid[j] && out_ready[j]) begin
                        if (exp_q[j].size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL out%0d_unexpected: got %0h expected no flit", j, out_data[j*DW +: DW]);
                        end else begin
                            check($sformatf("out%0d_data", j), NO*DW'(out_data[j*DW +: DW]), NO*DW'(exp_q[j].pop_front()));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int seq [NI];
        int order [6];
        logic [NO*DW-1:0] exp_vec;

        order = '{0, 1, 3, 0, 1, 3};
        for (int i = 0; i < NI; i++) seq[i] = 0;

        // Reset with live requests: nothing may be accepted.
        reset     = 1'b1;
        ON        = 1'b1;
        out_ready = '1;
        clear_in();
        set_flit(0, 1, 32'hDEAD_0000);
        tick("reset_in_ready", 5'b00000);
        tick("reset_in_ready2", 5'b00000);
        check("reset_out_valid", NO*DW'(out_valid), '0);
        check("reset_out_data", out_data, '0);
        check("reset_bad_dest", NO*DW'(bad_dest), '0);
        reset = 1'b0;
        clear_in();

        // Single flit, 1-cycle latency.
        set_flit(0, 2, 32'hA5A5_A5A5);
        tick("t1_ready", 5'b00001);
        clear_in();
        check("t1_out_valid", NO*DW'(out_valid), NO*DW'(5'b00100));
        check("t1_out_data2", NO*DW'(out_data[2*DW +: DW]), NO*DW'(32'hA5A5_A5A5));
        tick("t1_idle", 5'b00000);

        // Three-way contention for output 4.
        for (int c = 0; c < 6; c++) begin
            foreach (order[k]) begin
                if (k < 3) set_flit(order[k], 4, {8'(order[k] + 1), 24'(seq[order[k]])});
            end
            tick($sformatf("t2_grant%0d", c), NI'(1 << order[c]));
            seq[order[c]]++;
        end
        clear_in();
        tick("t2_idle", 5'b00000);

        // Backpressure on output 1, then same-cycle refill on release.
        out_ready[1] = 1'b0;
        set_flit(2, 1, 32'h1111_0001);
        tick("t3_first", 5'b00100);
        set_flit(2, 1, 32'h1111_0002);
        check("t3_hold_a", NO*DW'(out_data[DW +: DW]), NO*DW'(32'h1111_0001));
        tick("t3_stall", 5'b00000);
        check("t3_hold_b", NO*DW'(out_data[DW +: DW]), NO*DW'(32'h1111_0001));
        check("t3_valid_held", NO*DW'(out_valid), NO*DW'(5'b00010));
        out_ready[1] = 1'b1;
        tick("t3_resume", 5'b00100);
        clear_in();
        check("t3_new_flit", NO*DW'(out_data[DW +: DW]), NO*DW'(32'h1111_0002));
        tick("t3_idle", 5'b00000);

        // Illegal destination.
        set_flit(4, 6, 32'hBAD0_0004);
        tick("t4_ready", 5'b10000);
        clear_in();
        check("t4_bad_dest", NO*DW'(bad_dest), NO*DW'(5'b10000));
        check("t4_out_valid", NO*DW'(out_valid), '0);
        tick("t4_idle", 5'b00000);
        check("t4_bad_dest_clear", NO*DW'(bad_dest), '0);

        // ON = 0 freezes grants and pointers while output 0 drains.
        set_flit(1, 0, 32'h5555_0001);
        tick("t5_load", 5'b00010);
        clear_in();
        check("t5_loaded", NO*DW'(out_valid), NO*DW'(5'b00001));
        ON = 1'b0;
        set_flit(0, 0, 32'h5555_0100);
        set_flit(1, 0, 32'h5555_0101);
        set_flit(2, 0, 32'h5555_0102);
        set_flit(3, 7, 32'h5555_0103);
        tick("t5_off", 5'b00000);
        check("t5_drained", NO*DW'(out_valid), '0);
        check("t5_no_bad", NO*DW'(bad_dest), '0);
        tick("t5_off2", 5'b00000);
        ON = 1'b1;
        tick("t5_resume", 5'b01100);
        in_valid[2] = 1'b0;
        in_valid[3] = 1'b0;
        check("t5_bad_dest", NO*DW'(bad_dest), NO*DW'(5'b01000));
        tick("t5_next", 5'b00001);
        in_valid[0] = 1'b0;
        tick("t5_last", 5'b00010);
        clear_in();
        tick("t5_idle", 5'b00000);

        // Full permutation, then reset mid-stream.
        exp_vec = '0;
        for (int i = 0; i < NI; i++) begin
            set_flit(i, (i + 1) % NO, 32'hC000_0000 + DW'(i));
            exp_vec[((i + 1) % NO)*DW +: DW] = 32'hC000_0000 + DW'(i);
        end
        tick("t6_perm", 5'b11111);
        check("t6_out_valid", NO*DW'(out_valid), NO*DW'(5'b11111));
        check("t6_out_data", out_data, exp_vec);
        for (int i = 0; i < NI; i++) set_flit(i, (i + 1) % NO, 32'hC100_0000 + DW'(i));
        tick("t6_perm2", 5'b11111);
        reset = 1'b1;
        for (int j = 0; j < NO; j++) exp_q[j].delete();
        tick("t6_reset_ready", 5'b00000);
        check("t6_reset_valid", NO*DW'(out_valid), '0);
        reset = 1'b0;
        clear_in();
        tick("t6_idle", 5'b00000);

        for (int j = 0; j < NO; j++) begin
            check($sformatf("q%0d_empty", j), NO*DW'(exp_q[j].size()), '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
